// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage access controller.
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Size 2'b11 behaves as a word access everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// EX/MEM request, MEM/WB result and data-memory bus for mem_access_unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] store_data;
  logic [4:0]        dest_reg;
  logic              stall;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_reg;
  logic              addr_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, alu_addr, store_data, dest_reg,
    input  mem_rdata, mem_ack,
    output stall, wb_valid, wb_data, wb_reg, addr_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, alu_addr, store_data, dest_reg,
    output mem_rdata, mem_ack,
    input  stall, wb_valid, wb_data, wb_reg, addr_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store enables/data and load extract/extend.
module mem_lane_align import mem_pkg::*; (
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Half uses off[1] only and word ignores off, so low bits are naturally aligned.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = '0;
    case (i_st_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      SZ_HALF: begin
        o_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
      end
    endcase
  end

  always_comb begin
    w_byte    = i_ld_rdata[{i_ld_off, 3'b000} +: 8];
    w_half    = i_ld_rdata[{i_ld_off[1], 4'b0000} +: 16];
    o_ld_data = i_ld_rdata;
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{~i_ld_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_ld_data = {{16{~i_ld_unsigned & w_half[15]}}, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: IDLE -> ACCESS (wait for mem_ack) -> DONE.
// MEM_ALIGN_CHECK_EN: reject misaligned half/word accesses with an addr_err pulse.
module mem_access_unit import mem_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  mem_access_unit_if.slave bus
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we, r_uns, r_err;
  logic [1:0]        r_size, r_off;
  logic [4:0]        r_dest;
  logic [DATA_W-1:0] r_wb_data;
  logic [4:0]        r_wb_reg;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata, w_ldata;
  logic              w_mis, w_accept, w_fin;

  mem_lane_align u_align (
    .i_st_size     (bus.req_size),
    .i_st_off      (bus.alu_addr[1:0]),
    .i_st_data     (bus.store_data),
    .o_be          (w_be),
    .o_wdata       (w_wdata),
    .i_ld_size     (r_size),
    .i_ld_off      (r_off),
    .i_ld_unsigned (r_uns),
    .i_ld_rdata    (bus.mem_rdata),
    .o_ld_data     (w_ldata)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign w_mis = misaligned(bus.req_size, bus.alu_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;
  assign w_fin    = (r_state == ST_ACCESS) && bus.mem_ack;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.req_valid) w_next = w_mis ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (bus.mem_ack) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_uns     <= 1'b0;
      r_err     <= 1'b0;
      r_size    <= '0;
      r_off     <= '0;
      r_dest    <= '0;
      r_wb_data <= '0;
      r_wb_reg  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= {bus.alu_addr[ADDR_W-1:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_we    <= bus.req_we;
        r_uns   <= bus.req_unsigned;
        r_err   <= w_mis;
        r_size  <= bus.req_size;
        r_off   <= bus.alu_addr[1:0];
        r_dest  <= bus.dest_reg;
      end
      // Result registers only move on a completed load; stores leave them intact.
      if (w_fin && !r_we) begin
        r_wb_data <= w_ldata;
        r_wb_reg  <= r_dest;
      end
    end
  end

  // Gated with rst so the pipeline is released the instant reset is applied.
  assign bus.stall     = !rst && (w_accept || (r_state == ST_ACCESS));
  assign bus.mem_req   = (r_state == ST_ACCESS);
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_be    = r_be;
  assign bus.mem_wdata = r_wdata;
  assign bus.wb_valid  = (r_state == ST_DONE) && !r_we && !r_err;
  assign bus.wb_data   = r_wb_data;
  assign bus.wb_reg    = r_wb_reg;
`ifdef MEM_ALIGN_CHECK_EN
  assign bus.addr_err  = (r_state == ST_DONE) && r_err;
`else
  assign bus.addr_err  = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a lane/extension reference model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus();
  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Observations from the most recent transaction
  logic [31:0] o_addr, o_wdata, o_wbd;
  logic [3:0]  o_be;
  logic [4:0]  o_wbr;
  logic        o_we, o_stable, o_err, o_done;
  int          o_stall, o_acc, o_wbv;
  // Model of the registered writeback result
  logic [31:0] m_wbd;
  logic [4:0]  m_wbr;

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'b1100 : 4'b0011;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic uns, input logic [31:0] rd);
    int off = int'(a % 4);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF0000;
    end else v = rd;
    return v;
  endfunction

  // Drives one instruction from the current negedge until DONE has passed; records observations.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] dest,
                         input logic [31:0] rd, input int waits);
    bit fin = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
    bus.alu_addr = a; bus.store_data = d; bus.dest_reg = dest;
    o_stall = 0; o_acc = 0; o_wbv = -1; o_err = 0; o_stable = 1; o_done = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      #1;
      if (bus.stall) o_stall++;
      if (bus.wb_valid) o_wbv = c;
      if (bus.addr_err) o_err = 1;
      if (bus.mem_req) begin
        if (o_acc == 0) begin
          o_addr = bus.mem_addr; o_be = bus.mem_be; o_wdata = bus.mem_wdata; o_we = bus.mem_we;
        end else if (bus.mem_addr !== o_addr || bus.mem_be !== o_be ||
                     bus.mem_wdata !== o_wdata || bus.mem_we !== o_we) o_stable = 0;
        bus.mem_ack   = (o_acc == waits);
        bus.mem_rdata = (o_acc == waits) ? rd : $urandom;
        o_acc++;
      end else begin
        // Stray acks outside ACCESS must be ignored
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        if (c > 0 && !bus.stall) begin fin = 1; o_done = 1; end
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0; bus.mem_ack = 1'b0;
    o_wbd = bus.wb_data; o_wbr = bus.wb_reg;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = SZ_WORD; bus.req_unsigned = 1'b0;
    bus.alu_addr = 32'h40; bus.store_data = 32'h0; bus.dest_reg = 5'd1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
    #22;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
    checks++; if (bus.wb_valid !== 1'b0 || bus.addr_err !== 1'b0 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL rst_flags got=%b%b%b exp=000", bus.wb_valid, bus.addr_err, bus.mem_we); end
    checks++; if ({bus.mem_addr, bus.mem_be, bus.mem_wdata} !== 68'h0) begin
      failures++; $display("FAIL rst_bus got=%h/%h/%h exp=0", bus.mem_addr, bus.mem_be, bus.mem_wdata); end
    checks++; if ({bus.wb_data, bus.wb_reg} !== 37'h0) begin
      failures++; $display("FAIL rst_wb got=%h/%h exp=0", bus.wb_data, bus.wb_reg); end
    bus.req_valid = 1'b0; bus.mem_ack = 1'b0;
    m_wbd = 32'h0; m_wbr = 5'd0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_store();
    run_txn(1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 5'd3, 32'h0, 1);
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL wst_timeout got=%b exp=1", o_done); end
    checks++; if (o_be !== 4'b1111 || o_addr !== 32'h100) begin
      failures++; $display("FAIL wst_be_addr got=%b/%h exp=1111/00000100", o_be, o_addr); end
    checks++; if (o_wdata !== 32'hDEADBEEF || o_we !== 1'b1) begin
      failures++; $display("FAIL wst_wdata got=%h/%b exp=deadbeef/1", o_wdata, o_we); end
    checks++; if (o_stall != 3) begin failures++; $display("FAIL wst_stall got=%0d exp=3", o_stall); end
    checks++; if (o_wbv != -1 || o_stable !== 1'b1) begin
      failures++; $display("FAIL wst_wbv_stable got=%0d/%b exp=-1/1", o_wbv, o_stable); end
  endtask

  task automatic test_byte_load_signed();
    run_txn(1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 5'd7, 32'h80FF0011, 0);
    m_wbd = 32'hFFFFFF80; m_wbr = 5'd7;
    checks++; if (o_be !== 4'b1000 || o_addr !== 32'h100) begin
      failures++; $display("FAIL lb_be got=%b/%h exp=1000/00000100", o_be, o_addr); end
    checks++; if (o_wbd !== 32'hFFFFFF80 || o_wbr !== 5'd7) begin
      failures++; $display("FAIL lb_data got=%h/%0d exp=ffffff80/7", o_wbd, o_wbr); end
    checks++; if (o_wbv != 2 || o_stall != 2) begin
      failures++; $display("FAIL lb_timing got=wbv%0d/stall%0d exp=2/2", o_wbv, o_stall); end
  endtask

  task automatic test_half_load();
    run_txn(1'b0, SZ_HALF, 1'b1, 32'h102, 32'h0, 5'd9, 32'h8001ABCD, 2);
    checks++; if (o_wbd !== 32'h00008001 || o_be !== 4'b1100) begin
      failures++; $display("FAIL lhu_data got=%h/%b exp=00008001/1100", o_wbd, o_be); end
    checks++; if (o_wbv != 4) begin failures++; $display("FAIL lhu_wbv got=%0d exp=4", o_wbv); end
    run_txn(1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, 5'd10, 32'h8001ABCD, 0);
    m_wbd = 32'hFFFF8001; m_wbr = 5'd10;
    checks++; if (o_wbd !== 32'hFFFF8001 || o_wbr !== 5'd10) begin
      failures++; $display("FAIL lh_data got=%h/%0d exp=ffff8001/10", o_wbd, o_wbr); end
  endtask

  task automatic test_byte_store();
    run_txn(1'b1, SZ_BYTE, 1'b0, 32'h201, 32'h000000A5, 5'd4, 32'h0, 0);
    checks++; if (o_be !== 4'b0010 || o_wdata !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL sb_lane got=%b/%h exp=0010/a5a5a5a5", o_be, o_wdata); end
    checks++; if (o_wbd !== m_wbd || o_wbr !== m_wbr) begin
      failures++; $display("FAIL sb_wb_hold got=%h/%0d exp=%h/%0d", o_wbd, o_wbr, m_wbd, m_wbr); end
  endtask

  task automatic test_misaligned_word();
    run_txn(1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, 5'd12, 32'hCAFEF00D, 0);
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL mis_timeout got=%b exp=1", o_done); end
`ifdef MEM_ALIGN_CHECK_EN
    checks++; if (o_acc != 0 || o_err !== 1'b1 || o_wbv != -1) begin
      failures++; $display("FAIL mis_check got=acc%0d/err%b/wbv%0d exp=0/1/-1", o_acc, o_err, o_wbv); end
`else
    m_wbd = 32'hCAFEF00D; m_wbr = 5'd12;
    checks++; if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_err !== 1'b0) begin
      failures++; $display("FAIL mis_align got=%h/%b/%b exp=00000100/1111/0", o_addr, o_be, o_err); end
    checks++; if (o_wbd !== 32'hCAFEF00D) begin failures++; $display("FAIL mis_data got=%h exp=cafef00d", o_wbd); end
`endif
  endtask

  task automatic test_back_to_back_random();
    logic we, uns; logic [1:0] sz; logic [31:0] a, d, rd; logic [4:0] dest; int w;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
      a = $urandom; d = $urandom; rd = $urandom; dest = 5'($urandom_range(0, 31)); w = $urandom_range(0, 3);
`ifdef MEM_ALIGN_CHECK_EN
      if (sz == 2'd1) a = a & ~32'h1;
      if (sz >= 2'd2) a = a & ~32'h3;
`endif
      run_txn(we, sz, uns, a, d, dest, rd, w);
      if (!we) begin m_wbd = m_load(sz, a, uns, rd); m_wbr = dest; end
      checks++; if (o_done !== 1'b1 || o_acc != w + 1) begin
        failures++; $display("FAIL rnd%0d_access got=done%b/acc%0d exp=1/%0d", n, o_done, o_acc, w + 1); end
      checks++; if (o_addr !== (a & ~32'h3) || o_we !== we || o_stable !== 1'b1) begin
        failures++; $display("FAIL rnd%0d_addr got=%h/%b/%b exp=%h/%b/1", n, o_addr, o_we, o_stable, a & ~32'h3, we); end
      checks++; if (o_be !== m_be(sz, a)) begin
        failures++; $display("FAIL rnd%0d_be got=%b exp=%b", n, o_be, m_be(sz, a)); end
      checks++; if (o_wdata !== m_wdata(sz, d)) begin
        failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, o_wdata, m_wdata(sz, d)); end
      checks++; if (o_stall != w + 2 || o_wbv != (we ? -1 : w + 2)) begin
        failures++; $display("FAIL rnd%0d_timing got=stall%0d/wbv%0d exp=%0d/%0d", n, o_stall, o_wbv, w + 2, we ? -1 : w + 2); end
      checks++; if (o_wbd !== m_wbd || o_wbr !== m_wbr) begin
        failures++; $display("FAIL rnd%0d_wb got=%h/%0d exp=%h/%0d", n, o_wbd, o_wbr, m_wbd, m_wbr); end
    end
  endtask

  task automatic test_reset_mid_access();
    int wbv_seen = 0, req_seen = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = SZ_WORD; bus.req_unsigned = 1'b0;
    bus.alu_addr = 32'h300; bus.dest_reg = 5'd5; bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", bus.mem_req); end
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin
      failures++; $display("FAIL rstmid_drop got=req%b/stall%b exp=0/0", bus.mem_req, bus.stall); end
    bus.req_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.wb_valid) wbv_seen++;
      if (bus.mem_req || bus.stall) req_seen++;
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    checks++; if (wbv_seen != 0 || req_seen != 0) begin
      failures++; $display("FAIL rstmid_late_ack got=wbv%0d/req%0d exp=0/0", wbv_seen, req_seen); end
    checks++; if (bus.wb_data !== 32'h0) begin failures++; $display("FAIL rstmid_wb got=%h exp=0", bus.wb_data); end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_load_signed();
    test_half_load();
    test_byte_store();
    test_misaligned_word();
    test_back_to_back_random();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
